// File: rtl/gemm_tiled_array_ctrl_if.sv
// Signal bundle between the tiled GeMM controller and its SoC control port plus the A/B/C tile SRAMs.
// The master modport is the controller side. The slave modport is the SoC/SRAM side.
interface gemm_tiled_array_ctrl_if #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int AddrWidth    = 16,
  parameter int SizeWidth    = 8,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int K            = 4
);
  logic                            start_i;
  logic [SizeWidth-1:0]            m_tiles_i;
  logic [SizeWidth-1:0]            k_tiles_i;
  logic [SizeWidth-1:0]            n_tiles_i;
  logic                            b_layout_i;
  logic                            sram_a_req_o;
  logic [AddrWidth-1:0]            sram_a_addr_o;
  logic [InDataWidth*M*K-1:0]      sram_a_rdata_i;
  logic                            sram_b_req_o;
  logic [AddrWidth-1:0]            sram_b_addr_o;
  logic [InDataWidth*K*N-1:0]      sram_b_rdata_i;
  logic                            sram_c_we_o;
  logic [AddrWidth-1:0]            sram_c_addr_o;
  logic [OutDataWidth*M*N-1:0]     sram_c_wdata_o;
  logic                            busy_o;
  logic                            done_o;

  modport master (
    input  start_i, m_tiles_i, k_tiles_i, n_tiles_i, b_layout_i,
    input  sram_a_rdata_i, sram_b_rdata_i,
    output sram_a_req_o, sram_a_addr_o, sram_b_req_o, sram_b_addr_o,
    output sram_c_we_o, sram_c_addr_o, sram_c_wdata_o, busy_o, done_o
  );

  modport slave (
    output start_i, m_tiles_i, k_tiles_i, n_tiles_i, b_layout_i,
    output sram_a_rdata_i, sram_b_rdata_i,
    input  sram_a_req_o, sram_a_addr_o, sram_b_req_o, sram_b_addr_o,
    input  sram_c_we_o, sram_c_addr_o, sram_c_wdata_o, busy_o, done_o
  );
endinterface

// File: rtl/gemm_tiled_array_ctrl.sv
// Output-stationary tiled GeMM controller: walks (m,n,k) one tile per cycle and feeds an MxN array of K-wide MACs.
// Each finished C tile is written to the C SRAM.
module gemm_tiled_array_ctrl #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int AddrWidth    = 16,
  parameter int SizeWidth    = 8,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int K            = 4,
  parameter int RdLatency    = 1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  gemm_tiled_array_ctrl_if.master bus
);
  localparam int ProdWidth = 2 * InDataWidth;
  localparam int MulWidth  = 2 * SizeWidth + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e r_state, w_state_next;

  logic [SizeWidth-1:0] r_mt, r_kt, r_nt;
  logic                 r_layout;
  logic [SizeWidth-1:0] r_m, r_n, r_k;
  logic                 w_accept, w_zero, w_issue;
  logic                 w_k_last, w_n_last, w_m_last, w_last_issue;
  logic [MulWidth-1:0]  w_a_full, w_b_full, w_c_full;

  assign w_accept     = (r_state == IDLE) && bus.start_i;
  assign w_zero       = (bus.m_tiles_i == '0) || (bus.k_tiles_i == '0) || (bus.n_tiles_i == '0);
  assign w_issue      = (r_state == ISSUE);
  assign w_k_last     = (r_k == r_kt - SizeWidth'(1));
  assign w_n_last     = (r_n == r_nt - SizeWidth'(1));
  assign w_m_last     = (r_m == r_mt - SizeWidth'(1));
  assign w_last_issue = w_issue && w_k_last && w_n_last && w_m_last;

  assign w_a_full = MulWidth'(r_m) * MulWidth'(r_kt) + MulWidth'(r_k);
  assign w_b_full = r_layout ? (MulWidth'(r_k) * MulWidth'(r_nt) + MulWidth'(r_n))
                             : (MulWidth'(r_n) * MulWidth'(r_kt) + MulWidth'(r_k));
  assign w_c_full = MulWidth'(r_m) * MulWidth'(r_nt) + MulWidth'(r_n);

  // Latched job descriptor and the k-inner / n / m-outer loop counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mt     <= '0;
      r_kt     <= '0;
      r_nt     <= '0;
      r_layout <= 1'b0;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
    end else if (w_accept) begin
      r_mt     <= bus.m_tiles_i;
      r_kt     <= bus.k_tiles_i;
      r_nt     <= bus.n_tiles_i;
      r_layout <= bus.b_layout_i;
      r_m      <= '0;
      r_n      <= '0;
      r_k      <= '0;
    end else if (w_issue) begin
      if (!w_k_last) begin
        r_k <= r_k + SizeWidth'(1);
      end else begin
        r_k <= '0;
        if (!w_n_last) begin
          r_n <= r_n + SizeWidth'(1);
        end else begin
          r_n <= '0;
          r_m <= r_m + SizeWidth'(1);
        end
      end
    end
  end

  // Tag pipeline matching the SRAM read latency: valid, first-k, last-k and the C tile address.
  logic [RdLatency-1:0] r_pv, r_pf, r_pl;
  logic [AddrWidth-1:0] r_pa [RdLatency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pv <= '0;
      r_pf <= '0;
      r_pl <= '0;
      for (int i = 0; i < RdLatency; i++) r_pa[i] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pf[0] <= w_issue && (r_k == '0);
      r_pl[0] <= w_issue && w_k_last;
      r_pa[0] <= AddrWidth'(w_c_full);
      for (int i = 1; i < RdLatency; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  logic                 w_vld, w_first, w_last;
  logic [AddrWidth-1:0] w_tag_addr;
  assign w_vld      = r_pv[RdLatency-1];
  assign w_first    = r_pf[RdLatency-1];
  assign w_last     = r_pl[RdLatency-1];
  assign w_tag_addr = r_pa[RdLatency-1];

  logic [OutDataWidth*M*N-1:0] w_acc_next_flat;

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [ProdWidth-1:0] w_prod [K];
      logic [OutDataWidth-1:0]     w_dot, w_acc_next, r_acc;

      for (genvar gk = 0; gk < K; gk++) begin : g_mul
        assign w_prod[gk] =
          $signed(bus.sram_a_rdata_i[(gi*K+gk)*InDataWidth +: InDataWidth]) *
          $signed(bus.sram_b_rdata_i[(gk*N+gj)*InDataWidth +: InDataWidth]);
      end

      // Products are signed, so the size cast sign-extends; the sum wraps at OutDataWidth.
      always_comb begin
        w_dot = '0;
        for (int ki = 0; ki < K; ki++) w_dot = w_dot + OutDataWidth'(w_prod[ki]);
      end

      assign w_acc_next = w_first ? w_dot : (r_acc + w_dot);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    r_acc <= '0;
        else if (w_vld) r_acc <= w_acc_next;
      end

      assign w_acc_next_flat[(gi*N+gj)*OutDataWidth +: OutDataWidth] = w_acc_next;
    end
  end

  logic                        r_c_we;
  logic [AddrWidth-1:0]        r_c_addr;
  logic [OutDataWidth*M*N-1:0] r_c_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_c_we    <= 1'b0;
      r_c_addr  <= '0;
      r_c_wdata <= '0;
    end else begin
      r_c_we <= w_vld && w_last;
      if (w_vld && w_last) begin
        r_c_addr  <= w_tag_addr;
        r_c_wdata <= w_acc_next_flat;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // DRAIN ends on the write strobe that leaves no tile in flight.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start_i) w_state_next = w_zero ? DONE : ISSUE;
      ISSUE:   if (w_last_issue) w_state_next = DRAIN;
      DRAIN:   if (r_c_we && (r_pv == '0)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.sram_a_req_o   = w_issue;
  assign bus.sram_b_req_o   = w_issue;
  assign bus.sram_a_addr_o  = w_issue ? AddrWidth'(w_a_full) : '0;
  assign bus.sram_b_addr_o  = w_issue ? AddrWidth'(w_b_full) : '0;
  assign bus.sram_c_we_o    = r_c_we;
  assign bus.sram_c_addr_o  = r_c_addr;
  assign bus.sram_c_wdata_o = r_c_wdata;
  assign bus.busy_o         = (r_state == ISSUE) || (r_state == DRAIN);
  assign bus.done_o         = (r_state == DONE);
endmodule

// File: tb/tb_gemm_tiled_array_ctrl.sv
// Bench for gemm_tiled_array_ctrl: two instances (read latency 1 and 3) with behavioural SRAMs.
// Results are checked against a plain matrix-multiply reference model and a write-timing rule.
module tb_gemm_tiled_array_ctrl;
  localparam int IW = 8, OW = 32, AW = 16, SW = 8, M = 4, N = 4, K = 4;
  localparam int AWD = IW*M*K, BWD = IW*K*N, CWD = OW*M*N;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn    [2];
  logic           start   [2];
  logic [SW-1:0]  mt_s    [2];
  logic [SW-1:0]  kt_s    [2];
  logic [SW-1:0]  nt_s    [2];
  logic           lay_s   [2];
  logic           req     [2];
  logic           breq    [2];
  logic [AW-1:0]  a_addr  [2];
  logic [AW-1:0]  b_addr  [2];
  logic [AWD-1:0] a_rd    [2];
  logic [BWD-1:0] b_rd    [2];
  logic           we      [2];
  logic [AW-1:0]  c_addr  [2];
  logic [CWD-1:0] c_wd    [2];
  logic           busy    [2];
  logic           done    [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    gemm_tiled_array_ctrl_if #(.InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW),
                               .SizeWidth(SW), .M(M), .N(N), .K(K)) bus ();
    assign bus.start_i        = start[gi];
    assign bus.m_tiles_i      = mt_s[gi];
    assign bus.k_tiles_i      = kt_s[gi];
    assign bus.n_tiles_i      = nt_s[gi];
    assign bus.b_layout_i     = lay_s[gi];
    assign bus.sram_a_rdata_i = a_rd[gi];
    assign bus.sram_b_rdata_i = b_rd[gi];
    assign req[gi]    = bus.sram_a_req_o;
    assign breq[gi]   = bus.sram_b_req_o;
    assign a_addr[gi] = bus.sram_a_addr_o;
    assign b_addr[gi] = bus.sram_b_addr_o;
    assign we[gi]     = bus.sram_c_we_o;
    assign c_addr[gi] = bus.sram_c_addr_o;
    assign c_wd[gi]   = bus.sram_c_wdata_o;
    assign busy[gi]   = bus.busy_o;
    assign done[gi]   = bus.done_o;

    gemm_tiled_array_ctrl #(.InDataWidth(IW), .OutDataWidth(OW), .AddrWidth(AW), .SizeWidth(SW),
                            .M(M), .N(N), .K(K), .RdLatency((gi == 0) ? 1 : 3)) u_dut (
      .clk_i  (clk),
      .rst_ni (rstn[gi]),
      .bus    (bus)
    );
  end

  // Tile SRAMs: logical tiles la/lb, physical contents mem_a/mem_b, read pipe per instance.
  logic [AWD-1:0] la [256];
  logic [BWD-1:0] lb [256];
  logic [AWD-1:0] mem_a [256];
  logic [BWD-1:0] mem_b [256];
  logic [AWD-1:0] pa [2][3];
  logic [BWD-1:0] pb [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pa[d][0] <= req[d]  ? mem_a[a_addr[d][7:0]] : '0;
      pb[d][0] <= breq[d] ? mem_b[b_addr[d][7:0]] : '0;
      pa[d][1] <= pa[d][0];
      pb[d][1] <= pb[d][0];
      pa[d][2] <= pa[d][1];
      pb[d][2] <= pb[d][1];
    end
  end
  assign a_rd[0] = pa[0][0];
  assign b_rd[0] = pb[0][0];
  assign a_rd[1] = pa[1][2];
  assign b_rd[1] = pb[1][2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge, following whichever instance `sel` names.
  int sel = 0;
  int t0  = 0;
  logic           m_req, m_breq, m_we, m_busy, m_done;
  logic [AW-1:0]  m_aaddr, m_baddr, m_caddr;
  logic [CWD-1:0] m_cwd;
  assign m_req   = req[sel];
  assign m_breq  = breq[sel];
  assign m_we    = we[sel];
  assign m_busy  = busy[sel];
  assign m_done  = done[sel];
  assign m_aaddr = a_addr[sel];
  assign m_baddr = b_addr[sel];
  assign m_caddr = c_addr[sel];
  assign m_cwd   = c_wd[sel];

  typedef struct {
    int             rel;
    logic [AW-1:0]  addr;
    logic [CWD-1:0] data;
  } wr_t;
  wr_t wq[$];
  int  rel = 0, nreq = 0, breq_bad = 0, ndone = 0, done_rel = -1;
  logic busy1 = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    rel = cyc - t0;
    if (m_req) nreq++;
    if (m_req != m_breq) breq_bad++;
    if (rel == 1) busy1 = m_busy;
    if (m_we) begin
      w.rel  = rel;
      w.addr = m_caddr;
      w.data = m_cwd;
      wq.push_back(w);
      $display("C write dut%0d rel=%0d addr=%0d elem0=%0d", sel, rel, m_caddr, $signed(m_cwd[31:0]));
    end
    if (m_done) begin
      ndone++;
      done_rel = rel;
    end
  end

  int nchk = 0, npass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_w(input string name, input logic [CWD-1:0] act, input logic [CWD-1:0] exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h80;
    if (r == 1) return 8'h7f;
    return 8'($urandom);
  endfunction

  // Reference: C(m,n) = sum over kt of A(m,kt) * B(kt,n) on full 4x4 tiles, int32 wrapping.
  function automatic logic [CWD-1:0] model_c(input int m, input int n, input int kt, input int nt);
    logic [CWD-1:0] w;
    logic signed [7:0] av, bv;
    int s;
    w = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < kt; kk++) begin
          for (int e = 0; e < K; e++) begin
            av = la[m*kt+kk][(i*K+e)*IW +: IW];
            bv = lb[kk*nt+n][(e*N+j)*IW +: IW];
            s += int'(av) * int'(bv);
          end
        end
        w[(i*N+j)*OW +: OW] = s;
      end
    end
    return w;
  endfunction

  // mode 0: A=identity, B=1..16; 1: random; 2: all -128; 3: keep previous logical data.
  task automatic fill(input int mode, input int mt, input int kt, input int nt, input bit lay);
    if (mode != 3) begin
      for (int t = 0; t < mt*kt; t++)
        for (int i = 0; i < M; i++)
          for (int e = 0; e < K; e++)
            la[t][(i*K+e)*IW +: IW] = (mode == 0) ? ((i == e) ? 8'd1 : 8'd0) :
                                      (mode == 2) ? 8'h80 : rnd_byte();
      for (int t = 0; t < kt*nt; t++)
        for (int e = 0; e < K; e++)
          for (int j = 0; j < N; j++)
            lb[t][(e*N+j)*IW +: IW] = (mode == 0) ? 8'(e*N+j+1) :
                                      (mode == 2) ? 8'h80 : rnd_byte();
    end
    for (int t = 0; t < mt*kt; t++) mem_a[t] = la[t];
    for (int kk = 0; kk < kt; kk++)
      for (int n = 0; n < nt; n++)
        mem_b[lay ? (kk*nt+n) : (n*kt+kk)] = lb[kk*nt+n];
  endtask

  task automatic run(input string tag, input int d, input int mt, input int kt, input int nt,
                     input bit lay, input int mode, input int exp_done, input bit poke,
                     input bit chk15, input int exp15);
    int base_w, base_req, base_done, base_bad, nw, lat;
    wr_t w;
    lat = (d == 0) ? 1 : 3;
    fill(mode, mt, kt, nt, lay);
    sel = d;
    @(posedge clk); #1;
    base_w = wq.size(); base_req = nreq; base_done = ndone; base_bad = breq_bad;
    start[d] = 1'b1; mt_s[d] = 8'(mt); kt_s[d] = 8'(kt); nt_s[d] = 8'(nt); lay_s[d] = lay;
    t0 = cyc;
    @(posedge clk); #1;
    start[d] = 1'b0; mt_s[d] = 8'($urandom); kt_s[d] = 8'($urandom); nt_s[d] = 8'($urandom);
    lay_s[d] = ~lay;
    if (poke) begin
      repeat (2) @(posedge clk); #1;
      start[d] = 1'b1; kt_s[d] = 8'd0; mt_s[d] = 8'd1;
      @(posedge clk); #1;
      start[d] = 1'b0;
    end
    for (int c = 0; c < 400 && ndone == base_done; c++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    check({tag, "_done_pulses"}, ndone - base_done, 1);
    check({tag, "_done_cycle"}, done_rel, exp_done);
    check({tag, "_req_count"}, nreq - base_req, mt*kt*nt);
    check({tag, "_b_req_eq_a"}, breq_bad - base_bad, 0);
    check({tag, "_busy_at1"}, busy1, 1);
    check({tag, "_busy_after"}, m_busy, 0);
    nw = wq.size() - base_w;
    check({tag, "_n_writes"}, nw, mt*nt);
    for (int j = 0; j < nw && j < mt*nt; j++) begin
      w = wq[base_w+j];
      check($sformatf("%s_wr%0d_addr", tag, j), w.addr, j);
      check($sformatf("%s_wr%0d_cycle", tag, j), w.rel, (j+1)*kt + lat + 1);
      check_w($sformatf("%s_wr%0d_data", tag, j), w.data, model_c(j / nt, j % nt, kt, nt));
      if (chk15 && j == 0) check($sformatf("%s_elem15", tag), $signed(w.data[15*OW +: OW]), exp15);
    end
  endtask

  typedef struct {
    int d;
    int mt, kt, nt;
    bit lay;
    int mode;
    int exp_done;
    bit chk15;
    int exp15;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int base_w, base_req, base_done;
    tbl[0] = '{0, 1, 1, 1, 1'b0, 0,  4, 1'b1, 16};
    tbl[1] = '{0, 2, 3, 2, 1'b0, 1, 15, 1'b0, 0};
    tbl[2] = '{0, 2, 3, 2, 1'b1, 3, 15, 1'b0, 0};
    tbl[3] = '{1, 1, 8, 2, 1'b0, 2, 21, 1'b1, 524288};
    tbl[4] = '{0, 3, 2, 2, 1'b1, 1, 15, 1'b0, 0};
    tbl[5] = '{1, 2, 1, 3, 1'b0, 1, 11, 1'b0, 0};

    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; start[d] = 1'b0; mt_s[d] = '0; kt_s[d] = '0; nt_s[d] = '0; lay_s[d] = 1'b0;
    end
    repeat (3) @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      sel = d; #1;
      check($sformatf("reset_outs_dut%0d", d),
            {m_req, m_breq, m_we, m_busy, m_done, |m_aaddr, |m_baddr, |m_caddr, |m_cwd}, 0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 6; v++)
      run($sformatf("v%0d", v), tbl[v].d, tbl[v].mt, tbl[v].kt, tbl[v].nt, tbl[v].lay,
          tbl[v].mode, tbl[v].exp_done, 1'b0, tbl[v].chk15, tbl[v].exp15);

    // Start pulsed again while busy must not disturb the run.
    run("poke", 0, 2, 3, 2, 1'b0, 1, 15, 1'b1, 1'b0, 0);

    // Zero tile count: straight to DONE with no traffic.
    sel = 0;
    @(posedge clk); #1;
    base_w = wq.size(); base_req = nreq; base_done = ndone;
    start[0] = 1'b1; mt_s[0] = 8'd2; kt_s[0] = 8'd0; nt_s[0] = 8'd2; t0 = cyc;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("zero_done_pulses", ndone - base_done, 1);
    check("zero_done_cycle", done_rel, 1);
    check("zero_req_count", nreq - base_req, 0);
    check("zero_writes", wq.size() - base_w, 0);

    // Asynchronous reset in the middle of ISSUE, after one C write has landed.
    fill(2, 1, 8, 2, 1'b0);
    sel = 1;
    @(posedge clk); #1;
    start[1] = 1'b1; mt_s[1] = 8'd1; kt_s[1] = 8'd8; nt_s[1] = 8'd2; lay_s[1] = 1'b0; t0 = cyc;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (13) @(posedge clk); #2;
    check("midrst_pre_req", m_req, 1);
    check("midrst_pre_wdata_nz", (m_cwd != '0), 1);
    rstn[1] = 1'b0; #1;
    check("midrst_outs_zero",
          {m_req, m_breq, m_we, m_busy, m_done, |m_aaddr, |m_baddr, |m_caddr, |m_cwd}, 0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    repeat (2) @(posedge clk);
    run("rerun", 1, 1, 8, 2, 1'b0, 3, 21, 1'b0, 1'b1, 524288);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
